// File: rtl/apb_arb_pkg.sv
// Shared FSM encoding and default timeout for the APB request arbiter.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    localparam int unsigned TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; the pointer remembers the last winner so a tie
// goes to the other requester. Out of reset requester 0 wins the first tie.
module rr_arbiter2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] gnt_o
);

    logic last_q;

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = last_q ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= 1'b1;
        end else if (advance_i && (|req_i)) begin
            last_q <= gnt_o[1];
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Two requesters share one APB master port; writes use psel_0, reads psel_1.
// Every output is a register written from the single FSM process.
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned PADDR_WIDTH = 32,
    parameter int unsigned PDATA_WIDTH = 32,
    parameter int unsigned TIMEOUT     = TIMEOUT_DEFAULT
) (
    input  logic                   pclk,
    input  logic                   preset_n,
    input  logic                   req0_valid,
    input  logic                   req0_write,
    input  logic [PADDR_WIDTH-1:0] req0_addr,
    input  logic [PDATA_WIDTH-1:0] req0_wdata,
    output logic                   req0_ready,
    output logic                   rsp0_valid,
    output logic [PDATA_WIDTH-1:0] rsp0_rdata,
    output logic                   rsp0_err,
    input  logic                   req1_valid,
    input  logic                   req1_write,
    input  logic [PADDR_WIDTH-1:0] req1_addr,
    input  logic [PDATA_WIDTH-1:0] req1_wdata,
    output logic                   req1_ready,
    output logic                   rsp1_valid,
    output logic [PDATA_WIDTH-1:0] rsp1_rdata,
    output logic                   rsp1_err,
    output logic [PADDR_WIDTH-1:0] paddr,
    output logic                   pwrite,
    output logic                   psel_0,
    output logic                   psel_1,
    output logic                   penable,
    output logic [PDATA_WIDTH-1:0] pwdata,
    input  logic [PDATA_WIDTH-1:0] prdata,
    input  logic                   pready,
    input  logic                   pslverr,
    output logic                   timeout
);

    apb_state_e             state_q;
    logic                   owner_q;
    logic                   write_q;
    logic [PADDR_WIDTH-1:0] addr_q;
    logic [PDATA_WIDTH-1:0] wdata_q;
    logic [7:0]             cnt_q;
    logic                   psel0_q, psel1_q, penable_q;
    logic                   ready0_q, ready1_q;
    logic                   rsp0_valid_q, rsp1_valid_q;
    logic [PDATA_WIDTH-1:0] rsp0_rdata_q, rsp1_rdata_q;
    logic                   rsp0_err_q, rsp1_err_q;
    logic                   timeout_q;

    logic [1:0]             gnt;
    logic                   gnt_write;
    logic                   done_d;
    logic                   expired_d;
    logic                   rsp_err_d;
    logic [PDATA_WIDTH-1:0] rsp_rdata_d;

    rr_arbiter2 u_rr (
        .clk_i     (pclk),
        .rst_ni    (preset_n),
        .req_i     ({req1_valid, req0_valid}),
        .advance_i (state_q == ST_IDLE),
        .gnt_o     (gnt)
    );

    assign gnt_write = gnt[1] ? req1_write : req0_write;

    // A slave response in the last allowed cycle beats the timeout.
    always_comb begin
        done_d      = 1'b0;
        expired_d   = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        if (state_q == ST_ACCESS) begin
            if (pready || pslverr) begin
                done_d      = 1'b1;
                rsp_err_d   = pslverr;
                rsp_rdata_d = write_q ? '0 : prdata;
            end else if (cnt_q == 8'(TIMEOUT)) begin
                done_d    = 1'b1;
                expired_d = 1'b1;
                rsp_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            psel0_q      <= 1'b0;
            psel1_q      <= 1'b0;
            penable_q    <= 1'b0;
            ready0_q     <= 1'b0;
            ready1_q     <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
            rsp0_err_q   <= 1'b0;
            rsp1_err_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            ready0_q     <= 1'b0;
            ready1_q     <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (|gnt) begin
                        owner_q  <= gnt[1];
                        write_q  <= gnt_write;
                        addr_q   <= gnt[1] ? req1_addr : req0_addr;
                        wdata_q  <= gnt[1] ? req1_wdata : req0_wdata;
                        ready0_q <= gnt[0];
                        ready1_q <= gnt[1];
                        psel0_q  <= gnt_write;
                        psel1_q  <= !gnt_write;
                        state_q  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable_q <= 1'b1;
                    cnt_q     <= 8'd1;
                    state_q   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (done_d) begin
                        psel0_q   <= 1'b0;
                        psel1_q   <= 1'b0;
                        penable_q <= 1'b0;
                        cnt_q     <= '0;
                        timeout_q <= expired_d;
                        if (owner_q) begin
                            rsp1_valid_q <= 1'b1;
                            rsp1_rdata_q <= rsp_rdata_d;
                            rsp1_err_q   <= rsp_err_d;
                        end else begin
                            rsp0_valid_q <= 1'b1;
                            rsp0_rdata_q <= rsp_rdata_d;
                            rsp0_err_q   <= rsp_err_d;
                        end
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req0_ready = ready0_q;
    assign req1_ready = ready1_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_rdata = rsp0_rdata_q;
    assign rsp1_rdata = rsp1_rdata_q;
    assign rsp0_err   = rsp0_err_q;
    assign rsp1_err   = rsp1_err_q;
    assign paddr      = addr_q;
    assign pwrite     = write_q;
    assign pwdata     = wdata_q;
    assign psel_0     = psel0_q;
    assign psel_1     = psel1_q;
    assign penable    = penable_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Randomised two-requester traffic against a transaction-level model of the
// arbiter: round-robin winner, APB phase sequence, response and timeout.
module tb_apb_req_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 4;

    logic          pclk = 1'b0;
    logic          preset_n;
    logic          req0_valid, req0_write, req1_valid, req1_write;
    logic [AW-1:0] req0_addr, req1_addr, paddr;
    logic [DW-1:0] req0_wdata, req1_wdata, pwdata, prdata;
    logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp0_rdata, rsp1_rdata;
    logic          rsp0_err, rsp1_err;
    logic          pwrite, psel_0, psel_1, penable, pready, pslverr, timeout;

    always #5 pclk = ~pclk;

    apb_req_arbiter #(.PADDR_WIDTH(AW), .PDATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .pclk(pclk), .preset_n(preset_n),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready), .rsp0_valid(rsp0_valid),
        .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready), .rsp1_valid(rsp1_valid),
        .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .paddr(paddr), .pwrite(pwrite), .psel_0(psel_0), .psel_1(psel_1),
        .penable(penable), .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .timeout(timeout)
    );

    int unsigned nvec = 0;
    int unsigned nerr = 0;

    // Reference model: last winner, pending requests and held responses.
    int          last_gnt = 1;
    bit          pv[2];
    bit          pw[2];
    logic [31:0] pa[2];
    logic [31:0] pd[2];
    logic [31:0] exp_rd[2];
    bit          exp_err[2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic set_req(input int i, input bit w, input logic [31:0] a, input logic [31:0] d);
        pv[i] = 1'b1; pw[i] = w; pa[i] = a; pd[i] = d;
        if (i == 0) begin
            req0_valid = 1'b1; req0_write = w; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = 1'b1; req1_write = w; req1_addr = a; req1_wdata = d;
        end
    endtask

    // Called from an IDLE cycle with at least one request pending; returns in
    // the IDLE cycle following RESP.  kind: 0 pready, 1 pslverr, 2 both.
    task automatic do_xfer(input int unsigned n, input int unsigned kind, input logic [31:0] rd);
        int  win;
        int  lat;
        bit  to;
        bit  fin;
        int  kk;
        logic [31:0] erd;
        bit  eerr;
        if (pv[0] && pv[1]) win = (last_gnt == 0) ? 1 : 0;
        else                win = pv[1] ? 1 : 0;
        step();
        chk("ready", {req1_ready, req0_ready}, (win == 1) ? 2'b10 : 2'b01);
        chk("setup_sel", {psel_1, psel_0, penable}, pw[win] ? 3'b010 : 3'b100);
        chk("setup_addr", paddr, pa[win]);
        chk("setup_dir", pwrite, pw[win]);
        if (pw[win]) chk("setup_wdata", pwdata, pd[win]);
        last_gnt = win;
        pv[win] = 1'b0;
        if (win == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        lat = 1;
        step();
        lat++;
        to = 1'b0;
        fin = 1'b0;
        kk = 0;
        for (int k = 0; k < int'(TO) && !fin; k++) begin
            chk("access_sel", {psel_1, psel_0, penable}, pw[win] ? 3'b011 : 3'b101);
            chk("access_ready", {req1_ready, req0_ready}, 2'b00);
            chk("access_addr", paddr, pa[win]);
            pready  = (k == int'(n)) && (kind != 1);
            pslverr = (k == int'(n)) && (kind != 0);
            prdata  = (k == int'(n)) ? rd : $urandom;
            step();
            lat++;
            kk = k;
            if (k == int'(n)) fin = 1'b1;
            else if (k == int'(TO) - 1) begin fin = 1'b1; to = 1'b1; end
        end
        pready = 1'b0; pslverr = 1'b0;
        erd  = (to || pw[win]) ? 32'h0 : rd;
        eerr = to ? 1'b1 : (kind != 0);
        exp_rd[win] = erd;
        exp_err[win] = eerr;
        chk("rsp_valid", {rsp1_valid, rsp0_valid}, (win == 1) ? 2'b10 : 2'b01);
        chk("rsp_rdata", (win == 1) ? rsp1_rdata : rsp0_rdata, erd);
        chk("rsp_err", (win == 1) ? rsp1_err : rsp0_err, eerr);
        chk("timeout", timeout, to);
        chk("resp_gap", {psel_1, psel_0, penable}, 3'b000);
        chk("latency", lat, 3 + kk);
        step();
        chk("idle_pulses", {rsp1_valid, rsp0_valid, timeout, req1_ready, req0_ready}, 5'b0);
        chk("idle_sel", {psel_1, psel_0, penable}, 3'b000);
        chk("hold0", {rsp0_err, rsp0_rdata}, {exp_err[0], exp_rd[0]});
        chk("hold1", {rsp1_err, rsp1_rdata}, {exp_err[1], exp_rd[1]});
    endtask

    initial begin
        preset_n = 1'b0;
        req0_valid = 0; req0_write = 0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 0; req1_write = 0; req1_addr = '0; req1_wdata = '0;
        prdata = '0; pready = 0; pslverr = 0;
        for (int i = 0; i < 2; i++) begin
            pv[i] = 0; pw[i] = 0; pa[i] = '0; pd[i] = '0; exp_rd[i] = '0; exp_err[i] = 0;
        end
        repeat (2) step();
        chk("rst_bus", {psel_1, psel_0, penable, pwrite, paddr, pwdata}, '0);
        chk("rst_pulses", {rsp1_valid, rsp0_valid, timeout, req1_ready, req0_ready}, 5'b0);
        chk("rst_rsp", {rsp1_err, rsp0_err, rsp1_rdata, rsp0_rdata}, '0);
        @(negedge pclk);
        preset_n = 1'b1;
        step();

        set_req(0, 1'b1, 32'h10, 32'hA5A5A5A5);
        do_xfer(0, 0, 32'h0);
        set_req(1, 1'b0, 32'h20, 32'h0);
        do_xfer(2, 0, 32'h12345678);
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 2; i++)
                if (!pv[i]) set_req(i, t[0], 32'h100 + 32'(i * 4), $urandom);
            do_xfer(0, 0, $urandom);
        end
        set_req(0, 1'b1, 32'h30, 32'h5555AAAA);
        do_xfer(0, 1, 32'h0);
        set_req(1, 1'b0, 32'h34, 32'h0);
        do_xfer(0, 2, 32'hDEADBEEF);
        set_req(1, 1'b0, 32'h38, 32'h0);
        do_xfer(TO + 1, 0, 32'hCAFEF00D);

        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 2; i++)
                if (!pv[i] && $urandom_range(1, 0) == 1)
                    set_req(i, 1'($urandom_range(1, 0)), $urandom, $urandom);
            if (!pv[0] && !pv[1]) begin
                step();
                chk("no_req_idle", {req1_ready, req0_ready, psel_1, psel_0, penable}, 5'b0);
                set_req(0, 1'($urandom_range(1, 0)), $urandom, $urandom);
            end
            do_xfer($urandom_range(TO + 1, 0), $urandom_range(2, 0), $urandom);
        end

        // Reset during ACCESS: bus drops at once and no response follows.
        set_req(0, 1'b1, 32'h40, 32'h1234);
        step();
        req0_valid = 1'b0; pv[0] = 1'b0;
        step();
        chk("pre_rst_access", {psel_1, psel_0, penable}, 3'b011);
        #2 preset_n = 1'b0;
        #1;
        chk("rst_async_sel", {psel_1, psel_0, penable}, 3'b000);
        step();
        chk("rst_no_rsp", {rsp1_valid, rsp0_valid, timeout}, 3'b000);
        req1_valid = 1'b0;
        pv[1] = 1'b0;
        last_gnt = 1;
        exp_rd[0] = '0; exp_rd[1] = '0; exp_err[0] = 0; exp_err[1] = 0;
        @(negedge pclk);
        preset_n = 1'b1;
        step();
        chk("post_rst_idle", {rsp1_valid, rsp0_valid, psel_1, psel_0, penable}, 5'b0);
        set_req(0, 1'b0, 32'h50, 32'h0);
        set_req(1, 1'b1, 32'h54, 32'h99);
        do_xfer(1, 0, 32'h600DF00D);
        do_xfer(0, 0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/apb_req_arbiter.md
APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 Parameter PADDR_WIDTH, default 32, APB address width.
REQ-002 Parameter PDATA_WIDTH, default 32, APB data width.
REQ-003 Parameter TIMEOUT, default 16, maximum ACCESS-phase cycles before abort (range 2..255).
REQ-004 Clocking and reset: one clock; reset is asynchronous and active-low; ports are pclk and preset_n.
REQ-005 Ports (name, direction, width, meaning), one per line:
- pclk  in  1  clock.
- preset_n  in  1  async active-low reset.
- reqN_valid  in  1  requester N (N=0,1) transfer request.
- reqN_write  in  1  1=write, 0=read.
- reqN_addr  in  PADDR_WIDTH  transfer address.
- reqN_wdata  in  PDATA_WIDTH  write data.
- reqN_ready  out  1  one-cycle pulse; request N captured.
- rspN_valid  out  1  one-cycle pulse; transfer N complete.
- rspN_rdata  out  PDATA_WIDTH  read data, valid with rspN_valid.
- rspN_err  out  1  error or timeout, valid with rspN_valid.
- paddr  out  PADDR_WIDTH  APB address.
- pwrite  out  1  APB direction.
- psel_0  out  1  APB select, write transfers only.
- psel_1  out  1  APB select, read transfers only.
- penable  out  1  APB access phase.
- pwdata  out  PDATA_WIDTH  APB write data.
- prdata  in  PDATA_WIDTH  APB read data.
- pready  in  1  APB transfer done.
- pslverr  in  1  APB slave error.
- timeout  out  1  one-cycle pulse on ACCESS timeout.

Function
REQ-006 The FSM SHALL have four states: IDLE, SETUP, ACCESS, RESP; all outputs registered.
REQ-007 IDLE: if any reqN_valid, the block SHALL select a winner, pulse its reqN_ready, latch write/addr/wdata and owner, and go to SETUP; otherwise it stays in IDLE.
REQ-008 Arbitration SHALL be 2-way round robin: single requester wins; both requesting, the one not granted last wins; after reset req0 wins the first tie.
REQ-009 SETUP (exactly 1 cycle): the selected psel SHALL be high (psel_0 if write, psel_1 if read), penable low, paddr/pwrite/pwdata driven from latched values; go to ACCESS.
REQ-010 ACCESS: psel and penable SHALL be high; paddr/pwrite/pwdata held stable.
REQ-011 Completion: first ACCESS cycle sampling pready=1 or pslverr=1 SHALL end the transfer; err = sampled pslverr; rdata = prdata for reads, 0 for writes.
REQ-012 Timeout: a cycle counter SHALL count ACCESS cycles; if TIMEOUT cycles elapse with neither pready nor pslverr, the transfer ends with err=1, rdata=0, and timeout pulses 1 cycle.
REQ-013 On completion or timeout, psel_0/psel_1/penable SHALL drop low the next cycle, and the FSM goes to RESP.
REQ-014 RESP (exactly 1 cycle): the owner's rspN_valid SHALL pulse with rspN_rdata/rspN_err; psel low (mandatory bus gap); return to IDLE.
REQ-015 Minimum transfer latency, reqN_ready to rspN_valid: 3 cycles (SETUP, ACCESS with pready=1, RESP).
REQ-016 Requests SHALL be ignored outside IDLE (reqN_ready low); a requester holds valid and payload until ready; a valid dropped before ready is discarded.
REQ-017 psel_0 and psel_1 SHALL never be high together, and penable SHALL never be high without a psel.
REQ-018 rspN_rdata/rspN_err SHALL hold their last values between pulses.

Reset
REQ-019 On preset_n low, asynchronously: state IDLE, all outputs 0, counter 0, round-robin pointer favouring req0, latched payload 0.
REQ-020 Reset mid-transfer SHALL drop psel/penable immediately, issue no rsp pulse, and discard the in-flight transfer.

Structure
REQ-021 Package apb_arb_pkg SHALL hold the FSM state encoding (IDLE=0, SETUP=1, ACCESS=2, RESP=3) and the default TIMEOUT constant.
REQ-022 Sub-module rr_arbiter2 SHALL implement the 2-way round-robin grant and pointer; all other logic is in apb_req_arbiter.

Verification
REQ-023 req0 write addr 0x10 data 0xA5A5A5A5, pready 1 cycle after penable -> psel_0 SETUP then ACCESS, pwdata 0xA5A5A5A5, rsp0_valid with err=0 3 cycles after req0_ready.
REQ-024 req1 read; slave returns prdata 0x12345678 with pready after 3 ACCESS cycles -> psel_1 only, rsp1_rdata 0x12345678, err=0.
REQ-025 Both request continuously for 4 transfers -> grant order 0,1,0,1; one psel-low RESP cycle between transfers.
REQ-026 Write with pslverr=1 and pready=0 in the first ACCESS cycle -> rsp0_err=1, bus idle next cycle; read with pslverr=1 and pready=1 -> rsp1_err=1.
REQ-027 Slave silent, TIMEOUT=4 -> timeout pulse and rspN_err=1, rdata=0 after 4 ACCESS cycles; preset_n low during ACCESS -> psel/penable 0 immediately, no rsp pulse.
